// File: rtl/sa_skew_feeder.sv
// Operand feeder for an output-stationary systolic array: applies the per-lane diagonal skew,
// sequences clear/feed/flush for a K-beat job and pulses done when the last operand has landed.
module sa_skew_feeder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ROWS  = 64,
  parameter int unsigned COLS  = 64,
  parameter int unsigned KW    = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic [KW-1:0]         k_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH*ROWS-1:0] a_in,
  input  logic [WIDTH*COLS-1:0] b_in,
  output logic [WIDTH*ROWS-1:0] a_out,
  output logic [WIDTH*COLS-1:0] b_out,
  output logic                  pe_clear,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned FW = $clog2(ROWS + COLS);
  // Flush lasts ROWS+COLS-1 cycles, counted 0 .. ROWS+COLS-2.
  localparam logic [FW-1:0] FlushLast = FW'(ROWS + COLS - 2);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StFeed,
    StFlush,
    StDone
  } state_e;

  state_e        state_q, state_d;
  logic [KW-1:0] k_len_q, k_len_d;
  logic [KW-1:0] beat_cnt_q, beat_cnt_d;
  logic [FW-1:0] flush_cnt_q, flush_cnt_d;
  logic          accept;

  // Decoded from state rather than in_ready so no path exists from in_valid to in_ready.
  assign accept = in_valid && (state_q == StFeed);

  always_comb begin
    state_d     = state_q;
    k_len_d     = k_len_q;
    beat_cnt_d  = beat_cnt_q;
    flush_cnt_d = flush_cnt_q;
    in_ready    = 1'b0;
    pe_clear    = 1'b0;
    done        = 1'b0;
    busy        = (state_q != StIdle);
    unique case (state_q)
      StIdle: begin
        if (start) begin
          k_len_d     = k_len;
          beat_cnt_d  = '0;
          flush_cnt_d = '0;
          state_d     = (k_len != '0) ? StClear : StDone;
        end
      end
      StClear: begin
        pe_clear = 1'b1;
        state_d  = StFeed;
      end
      StFeed: begin
        in_ready = 1'b1;
        if (in_valid) begin
          beat_cnt_d = beat_cnt_q + KW'(1);
          if (beat_cnt_q == k_len_q - KW'(1)) begin
            flush_cnt_d = '0;
            state_d     = StFlush;
          end
        end
      end
      StFlush: begin
        if (flush_cnt_q == FlushLast) begin
          state_d = StDone;
        end else begin
          flush_cnt_d = flush_cnt_q + FW'(1);
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= StIdle;
      k_len_q     <= '0;
      beat_cnt_q  <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      k_len_q     <= k_len_d;
      beat_cnt_q  <= beat_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // A lane i: i+1 registers, shifting every cycle; zeros enter on bubbles and during flush.
  for (genvar i = 0; i < ROWS; i++) begin : g_a_lane
    logic [WIDTH-1:0] sr_q [i+1];

    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        for (int k = 0; k <= i; k++) begin
          sr_q[k] <= '0;
        end
      end else begin
        sr_q[0] <= accept ? a_in[i*WIDTH +: WIDTH] : '0;
        for (int k = 1; k <= i; k++) begin
          sr_q[k] <= sr_q[k-1];
        end
      end
    end

    assign a_out[i*WIDTH +: WIDTH] = sr_q[i];
  end

  for (genvar j = 0; j < COLS; j++) begin : g_b_lane
    logic [WIDTH-1:0] sr_q [j+1];

    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        for (int k = 0; k <= j; k++) begin
          sr_q[k] <= '0;
        end
      end else begin
        sr_q[0] <= accept ? b_in[j*WIDTH +: WIDTH] : '0;
        for (int k = 1; k <= j; k++) begin
          sr_q[k] <= sr_q[k-1];
        end
      end
    end

    assign b_out[j*WIDTH +: WIDTH] = sr_q[j];
  end

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Bench for sa_skew_feeder: jobs are driven cycle by cycle and every output is compared with a
// schedule derived from job length, accepted beats and the lane-delay rule.
module tb_sa_skew_feeder;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned ROWS  = 4;
  localparam int unsigned COLS  = 4;
  localparam int unsigned KW    = 8;
  localparam int unsigned AW    = WIDTH * ROWS;
  localparam int unsigned BW    = WIDTH * COLS;
  localparam int          MaxCyc = 400;

  logic          CLK;
  logic          RST;
  logic          start;
  logic [KW-1:0] k_len;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] a_in;
  logic [BW-1:0] b_in;
  logic [AW-1:0] a_out;
  logic [BW-1:0] b_out;
  logic          pe_clear;
  logic          busy;
  logic          done;

  int vectors;
  int miscompares;
  bit hold_start;

  // Vector pushed into the skew lines at each job-relative cycle (zero when nothing accepted).
  logic [AW-1:0]    pa [MaxCyc];
  logic [BW-1:0]    pb [MaxCyc];
  logic [WIDTH-1:0] obs_a0 [MaxCyc];
  logic [WIDTH-1:0] obs_a3 [MaxCyc];

  sa_skew_feeder #(
    .WIDTH(WIDTH),
    .ROWS (ROWS),
    .COLS (COLS),
    .KW   (KW)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .start   (start),
    .k_len   (k_len),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a_in    (a_in),
    .b_in    (b_in),
    .a_out   (a_out),
    .b_out   (b_out),
    .pe_clear(pe_clear),
    .busy    (busy),
    .done    (done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [AW-1:0] rand_a();
    logic [AW-1:0] v;
    for (int l = 0; l < int'(ROWS); l++) v[l*WIDTH +: WIDTH] = WIDTH'($urandom);
    return v;
  endfunction

  function automatic logic [BW-1:0] rand_b();
    logic [BW-1:0] v;
    for (int l = 0; l < int'(COLS); l++) v[l*WIDTH +: WIDTH] = WIDTH'($urandom);
    return v;
  endfunction

  // Runs one job whose start is sampled in job cycle 0 (an IDLE cycle) and checks every output
  // each cycle. vmode: 0 always valid, 1 valid except cycle 3, 2 random bubbles.
  task automatic run_job(input int k, input int vmode, input bit rand_data, output int done_cyc);
    int            n;
    int            last;
    int            idx;
    bit            fin;
    bit            vld;
    bit            exp_ready, exp_clear, exp_busy, exp_done;
    logic [AW-1:0] va, ea;
    logic [BW-1:0] vb, eb;
    n        = 0;
    last     = -1;
    fin      = 1'b0;
    done_cyc = -1;
    for (int c = 0; c < MaxCyc; c++) begin
      pa[c] = '0; pb[c] = '0; obs_a0[c] = '0; obs_a3[c] = '0;
    end
    for (int c = 0; c < MaxCyc && !fin; c++) begin
      exp_clear = (k != 0) && (c == 1);
      exp_ready = (k != 0) && (c >= 2) && (last < 0);
      exp_done  = (k == 0) ? (c == 1) : (last >= 0 && c == last + int'(ROWS + COLS));
      exp_busy  = (c >= 1);
      if (!exp_ready)      vld = 1'($urandom_range(0, 1));
      else if (vmode == 0) vld = 1'b1;
      else if (vmode == 1) vld = (c != 3);
      else                 vld = ($urandom_range(0, 99) >= 30);
      if (!vld || rand_data) begin
        va = rand_a();
        vb = rand_b();
      end else begin
        for (int l = 0; l < int'(ROWS); l++) va[l*WIDTH +: WIDTH] = WIDTH'(n + 1);
        for (int l = 0; l < int'(COLS); l++) vb[l*WIDTH +: WIDTH] = WIDTH'(n + 1);
      end
      start    = (c == 0) ? 1'b1 : (hold_start ? 1'b1 : 1'($urandom_range(0, 1)));
      k_len    = (c == 0) ? KW'(k) : KW'($urandom);
      in_valid = vld;
      a_in     = va;
      b_in     = vb;
      @(negedge CLK);
      for (int i = 0; i < int'(ROWS); i++) begin
        idx = c - i - 1;
        ea[i*WIDTH +: WIDTH] = (idx >= 0) ? pa[idx][i*WIDTH +: WIDTH] : '0;
      end
      for (int j = 0; j < int'(COLS); j++) begin
        idx = c - j - 1;
        eb[j*WIDTH +: WIDTH] = (idx >= 0) ? pb[idx][j*WIDTH +: WIDTH] : '0;
      end
      vectors += 6;
      if (in_ready !== exp_ready) begin
        miscompares++;
        $display("FAIL in_ready k=%0d cyc=%0d got=%b exp=%b", k, c, in_ready, exp_ready);
      end
      if (pe_clear !== exp_clear) begin
        miscompares++;
        $display("FAIL pe_clear k=%0d cyc=%0d got=%b exp=%b", k, c, pe_clear, exp_clear);
      end
      if (busy !== exp_busy) begin
        miscompares++;
        $display("FAIL busy k=%0d cyc=%0d got=%b exp=%b", k, c, busy, exp_busy);
      end
      if (done !== exp_done) begin
        miscompares++;
        $display("FAIL done k=%0d cyc=%0d got=%b exp=%b", k, c, done, exp_done);
      end
      if (a_out !== ea) begin
        miscompares++;
        $display("FAIL a_out k=%0d cyc=%0d got=%h exp=%h", k, c, a_out, ea);
      end
      if (b_out !== eb) begin
        miscompares++;
        $display("FAIL b_out k=%0d cyc=%0d got=%h exp=%h", k, c, b_out, eb);
      end
      obs_a0[c] = a_out[WIDTH-1:0];
      obs_a3[c] = a_out[3*WIDTH +: WIDTH];
      if (exp_ready && vld) begin
        pa[c] = va;
        pb[c] = vb;
        n++;
        if (n == k) last = c;
      end
      if (exp_done) begin
        done_cyc = c;
        fin      = 1'b1;
      end
      @(posedge CLK);
      #1;
    end
    if (done_cyc < 0) begin
      vectors++;
      miscompares++;
      $display("FAIL job_timeout k=%0d got=no_done exp=done_within_%0d", k, MaxCyc);
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    for (int c = 0; c < 4; c++) begin
      start    = 1'($urandom_range(0, 1));
      k_len    = KW'($urandom);
      in_valid = 1'($urandom_range(0, 1));
      a_in     = rand_a();
      b_in     = rand_b();
      @(negedge CLK);
      vectors++;
      if ({a_out, b_out} !== '0 || {in_ready, pe_clear, busy, done} !== 4'b0) begin
        miscompares++;
        $display("FAIL reset cyc=%0d got=%h/%h ctl=%b exp=0", c, a_out, b_out,
                 {in_ready, pe_clear, busy, done});
      end
      @(posedge CLK);
      #1;
    end
    RST = 1'b1;
  endtask

  task automatic test_basic();
    int d;
    logic [WIDTH-1:0] e;
    hold_start = 1'b0;
    run_job(3, 0, 1'b0, d);
    vectors++;
    if (d !== 12) begin
      miscompares++;
      $display("FAIL basic_done_cycle got=%0d exp=12", d);
    end
    for (int t = 0; t < 3; t++) begin
      e = WIDTH'(t + 1);
      vectors += 2;
      if (obs_a0[3+t] !== e) begin
        miscompares++;
        $display("FAIL basic_lane0 cyc=%0d got=%0d exp=%0d", 3 + t, obs_a0[3+t], e);
      end
      if (obs_a3[6+t] !== e) begin
        miscompares++;
        $display("FAIL basic_lane3 cyc=%0d got=%0d exp=%0d", 6 + t, obs_a3[6+t], e);
      end
    end
  endtask

  task automatic test_bubbles();
    int d;
    int exp_seq [4];
    logic [WIDTH-1:0] e;
    exp_seq    = '{1, 0, 2, 3};
    hold_start = 1'b0;
    run_job(3, 1, 1'b0, d);
    vectors++;
    if (d !== 13) begin
      miscompares++;
      $display("FAIL bubble_done_cycle got=%0d exp=13", d);
    end
    for (int t = 0; t < 4; t++) begin
      e = WIDTH'(exp_seq[t]);
      vectors++;
      if (obs_a0[3+t] !== e) begin
        miscompares++;
        $display("FAIL bubble_lane0 cyc=%0d got=%0d exp=%0d", 3 + t, obs_a0[3+t], e);
      end
    end
  endtask

  task automatic test_k_zero();
    int d;
    hold_start = 1'b0;
    run_job(0, 2, 1'b1, d);
    vectors++;
    if (d !== 1) begin
      miscompares++;
      $display("FAIL kzero_done_cycle got=%0d exp=1", d);
    end
  endtask

  task automatic test_start_held();
    int d1;
    int d2;
    hold_start = 1'b1;
    run_job(3, 0, 1'b0, d1);
    hold_start = 1'b0;
    run_job(2, 0, 1'b0, d2);
    vectors += 2;
    if (d1 !== 12) begin
      miscompares++;
      $display("FAIL held_first_done got=%0d exp=12", d1);
    end
    if (d2 !== 11) begin
      miscompares++;
      $display("FAIL held_second_done got=%0d exp=11", d2);
    end
  endtask

  task automatic test_reset_mid_feed();
    int d;
    for (int c = 0; c < 4; c++) begin
      start    = (c == 0);
      k_len    = KW'(5);
      in_valid = 1'b1;
      a_in     = rand_a();
      b_in     = rand_b();
      @(posedge CLK);
      #1;
    end
    #2 RST = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++;
      if ({a_out, b_out} !== '0 || {in_ready, pe_clear, busy, done} !== 4'b0) begin
        miscompares++;
        $display("FAIL midreset step=%0d got=%h/%h ctl=%b exp=0", c, a_out, b_out,
                 {in_ready, pe_clear, busy, done});
      end
      @(negedge CLK);
    end
    @(posedge CLK);
    #1;
    RST        = 1'b1;
    hold_start = 1'b0;
    run_job(2, 0, 1'b1, d);
    vectors++;
    if (d !== 11) begin
      miscompares++;
      $display("FAIL midreset_job_done got=%0d exp=11", d);
    end
  endtask

  task automatic test_random_jobs();
    int d;
    int k;
    for (int j = 0; j < 8; j++) begin
      k          = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 6));
      hold_start = (j < 7) && ($urandom_range(0, 1) == 1);
      run_job(k, 2, 1'b1, d);
    end
    hold_start = 1'b0;
    start      = 1'b0;
    in_valid   = 1'b0;
    @(negedge CLK);
    vectors++;
    if ({busy, done, in_ready, pe_clear} !== 4'b0) begin
      miscompares++;
      $display("FAIL final_idle got=%b exp=0000", {busy, done, in_ready, pe_clear});
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    hold_start  = 1'b0;
    RST         = 1'b0;
    start       = 1'b0;
    k_len       = '0;
    in_valid    = 1'b0;
    a_in        = '0;
    b_in        = '0;
    test_reset();
    test_basic();
    test_bubbles();
    test_k_zero();
    test_start_held();
    test_reset_mid_feed();
    test_random_jobs();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sa_skew_feeder.md
Name: sa_skew_feeder

Overview:
Parametrised operand feeder for the ROWS x COLS output-stationary systolic array (sa_2D family). Accepts one unskewed A vector and one unskewed B vector per beat through a valid/ready handshake. Applies the diagonal skew so lane i is delayed i cycles, and counts K reduction steps. It then flushes with zeros until the last operand reaches PE(ROWS-1,COLS-1), and signals completion. This replaces hand-built staggered stimulus and lets the array run back-to-back jobs of any K.

Parameters:
WIDTH, 32, operand width per lane (bits)
ROWS, 64, A lanes (array rows)
COLS, 64, B lanes (array columns)
KW, 16, width of the K-length field

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous active-low reset
start  input  1  job start request; sampled only in IDLE
k_len  input  KW  number of beats in the job; sampled with start
in_valid  input  1  a_in/b_in hold a valid beat
in_ready  output  1  feeder accepts a beat this cycle
a_in  input  WIDTH*ROWS  A vector; lane i = bits [(i+1)*WIDTH-1 : i*WIDTH]
b_in  input  WIDTH*COLS  B vector; same lane packing
a_out  output  WIDTH*ROWS  skewed A to array; same packing
b_out  output  WIDTH*COLS  skewed B to array; same packing
pe_clear  output  1  one-cycle accumulator clear to all PEs
busy  output  1  state != IDLE
done  output  1  one-cycle pulse at job end

Behaviour:
- Reset (RST=0, async): state=IDLE; beat and flush counters=0; all skew registers=0. Outputs: a_out=0, b_out=0, in_ready=0, pe_clear=0, busy=0, done=0.
- Skew lines:
  - A lane i is a shift chain of i+1 registers; B lane j has j+1 registers.
  - Every chain shifts on every clock, in all states.
  - Push value is the lane of a_in/b_in when in_valid && in_ready, otherwise 0.
  - A beat accepted at cycle c appears on a_out lane i during cycle c+i+1, and on b_out lane j during cycle c+j+1.
- FSM states: IDLE, CLEAR, FEED, FLUSH, DONE.
  - IDLE: in_ready=0. On start=1, latch k_len.
    - k_len!=0: go to CLEAR.
    - k_len==0: go to DONE; no pe_clear is issued.
  - CLEAR: pe_clear=1 for exactly this one cycle, then FEED.
  - FEED: in_ready=1.
    - Each handshake increments the beat counter.
    - in_valid=0 is a bubble: zeros are pushed and the counter is unchanged.
    - When the k_len-th beat is accepted, in the same cycle, go to FLUSH. in_ready drops the next cycle.
  - FLUSH: in_ready=0; zeros are pushed. Lasts exactly ROWS+COLS-1 cycles, then DONE.
  - DONE: done=1 for one cycle, then IDLE.
- start while busy is ignored; k_len is not re-sampled.
- Bubbles are legal because A and B zeros enter the same cycle, so they add 0 to every accumulator.
- Beat counter is KW bits and compares against the latched k_len. The maximum job is 2^KW-1 beats, with no wrap inside a job.
- Flush counter width is clog2(ROWS+COLS).
- Reset asserted mid-job aborts immediately: skew contents are dropped, outputs go to reset values, and no done is produced.
- No combinational path from in_valid to in_ready; in_ready is a function of state only.

Test Plan:
1. Reset: hold RST=0 with random a_in/b_in/start -> a_out=b_out=0; in_ready=pe_clear=busy=done=0.
2. Basic job (WIDTH=8, ROWS=COLS=4), k_len=3, in_valid=1, beat n sets all lanes to n; start at cycle 0:
   - pe_clear high in cycle 1; in_ready high cycles 2-4.
   - a_out lane0 = 1,2,3 in cycles 3-5; a_out lane3 = 1,2,3 in cycles 6-8.
   - FLUSH in cycles 5-11; done in cycle 12; busy low from cycle 13.
3. Bubbles: same job with in_valid=0 in cycle 3 -> beats accepted in cycles 2,4,5; a_out lane0 = 1,0,2,3 over cycles 3-6; done in cycle 13.
4. k_len=0: start -> done one cycle later; pe_clear never asserted; a_out/b_out stay 0.
5. start held high through a whole job -> no second pe_clear until IDLE. A new job begins the cycle after IDLE is re-entered, using the k_len present then.
6. Reset mid-FEED after beat 2 -> all outputs 0 immediately. After release, a fresh k_len=2 job completes with correct skew and a single done.
